// File: rtl/prefix_pkg.sv
// prefix_pkg: shared constants and result record for the add/sub slice.
// Op encoding, adder latency, data width and flag helpers live here.
package prefix_pkg;

  localparam int PREFIX_LAT = 5;
  localparam int PREFIX_DW  = 32;

  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;

  // Result record minus the tag; the tag is appended
  // at the low end because its width is a top parameter.
  typedef struct packed {
    logic [PREFIX_DW-1:0] y;
    logic                 cout;
    logic                 ovf;
    logic                 zero;
    logic                 neg;
  } res_core_t;

  localparam int RES_CORE_W = $bits(res_core_t);

  // Signed overflow: operands agree in sign, result does not.
  function automatic logic addsub_ovf(
    input logic a31,
    input logic b31,
    input logic y31
  );
    return (a31 == b31) && (y31 != a31);
  endfunction

  // Clamp target on overflow, chosen by the sign of A.
  function automatic logic [PREFIX_DW-1:0] sat_value(
    input logic a31
  );
    logic [PREFIX_DW-1:0] v;
    v = {1'b0, {(PREFIX_DW-1){1'b1}}};
    if (a31) v = {1'b1, {(PREFIX_DW-1){1'b0}}};
    return v;
  endfunction

  function automatic res_core_t make_core(
    input logic [PREFIX_DW-1:0] y,
    input logic                 cout,
    input logic                 ovf
  );
    res_core_t r;
    r.y    = y;
    r.cout = cout;
    r.ovf  = ovf;
    r.zero = (y == '0);
    r.neg  = y[PREFIX_DW-1];
    return r;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// result_fifo: DEPTH x W synchronous FIFO with occupancy count.
// Head is read straight from storage; zero when empty.
module result_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    logic [AW-1:0] r;
    r = p + AW'(1);
    if (p == AW'(DEPTH - 1)) r = '0;
    return r;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Pointers and occupancy; both ends wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data-only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Upstream credit must keep a push from ever meeting a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full && !do_pop))
        else $error("result_fifo: push into full fifo");
    end
  end

endmodule

// File: rtl/prefix_addsub_issue.sv
// prefix_addsub_issue: issue/retire wrapper for the pipelined prefix adder.
// Define PREFIX_ADDSUB_SAT_EN to clamp overflowed results.
module prefix_addsub_issue
  import prefix_pkg::*;
#(
  parameter int LAT   = PREFIX_LAT,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_c0,
  input  logic [31:0]      add_y,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int REC_W = RES_CORE_W + TAG_W;

  logic             is_sub;
  logic             acc;

  logic [LAT-1:0]   sb_vld;
  logic [LAT-1:0]   sb_a31;
  logic [LAT-1:0]   sb_b31;
  logic [TAG_W-1:0] sb_tag [LAT];

  logic [CW:0]      inflight;
  logic [CW-1:0]    fcount;
  logic             credit_ok;

  logic             ret_ovf;
  logic [31:0]      ret_y;
  res_core_t        ret_core;
  logic [REC_W-1:0] ret_rec;

  logic [REC_W-1:0] head_rec;
  res_core_t        head_core;
  logic             pop;

  // Operand formation: SUB is A + ~B + 1.
  assign is_sub = (in_op == ADDSUB_OP_SUB);
  assign add_a  = in_a;
  assign add_b  = in_b ^ {32{is_sub}};
  assign add_c0 = is_sub ? 1'b1 : in_cin;

  assign in_ready = rst_n & credit_ok;
  assign acc      = in_valid & in_ready;

  // Valid bits follow the adder; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_vld <= '0;
    end else begin
      sb_vld <= {sb_vld[LAT-2:0], acc};
    end
  end

  // Sideband data rides beside the adder; validity gates its use.
  always_ff @(posedge clk) begin
    sb_a31    <= {sb_a31[LAT-2:0], add_a[31]};
    sb_b31    <= {sb_b31[LAT-2:0], add_b[31]};
    sb_tag[0] <= in_tag;
    for (int i = 1; i < LAT; i++) begin
      sb_tag[i] <= sb_tag[i-1];
    end
  end

  // Credit: every in-flight op already owns a FIFO slot;
  // a same-cycle pop is not counted to avoid a path from out_ready.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + {{CW{1'b0}}, sb_vld[i]};
    end
    credit_ok = (({1'b0, fcount} + inflight) < (CW + 1)'(DEPTH));
  end

  // Retire: flags from the aligned sideband and adder result.
  always_comb begin
    ret_ovf = addsub_ovf(sb_a31[LAT-1], sb_b31[LAT-1], add_y[31]);
    ret_y   = add_y;
`ifdef PREFIX_ADDSUB_SAT_EN
    if (ret_ovf) ret_y = sat_value(sb_a31[LAT-1]);
`endif
    ret_core = make_core(ret_y, add_cout, ret_ovf);
    ret_rec  = {ret_core, sb_tag[LAT-1]};
  end

  assign pop = out_valid & out_ready;

  result_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sb_vld[LAT-1]),
    .din   (ret_rec),
    .pop   (pop),
    .dout  (head_rec),
    .valid (out_valid),
    .count (fcount)
  );

  assign head_core = res_core_t'(head_rec[REC_W-1:TAG_W]);
  assign out_y     = head_core.y;
  assign out_cout  = head_core.cout;
  assign out_ovf   = head_core.ovf;
  assign out_zero  = head_core.zero;
  assign out_neg   = head_core.neg;
  assign out_tag   = head_rec[TAG_W-1:0];

endmodule
